// File: rtl/evm_result_unit.sv
// EVM result unit: snapshots the four candidate tallies when the election locks, scans them
// for winner/tie/total and drives a rotating display feed. Optional macro: TAMPER_CHECK_EN.
module evm_result_unit #(
   parameter int          CNT_W = 8,
   parameter int unsigned DWELL = 32'd50000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             locked,
   input  logic [CNT_W-1:0] count1,
   input  logic [CNT_W-1:0] count2,
   input  logic [CNT_W-1:0] count3,
   input  logic [CNT_W-1:0] count4,
   output logic             busy,
   output logic             done,
   output logic [1:0]       winner,
   output logic             winner_valid,
   output logic             tie,
   output logic [CNT_W-1:0] max_count,
   output logic [CNT_W+1:0] total,
   output logic [1:0]       disp_sel,
   output logic [CNT_W-1:0] disp_count
`ifdef TAMPER_CHECK_EN
   ,
   output logic             tamper
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [31:0] DWELL_LAST = 32'(DWELL - 32'd1);

   state_t           state_r;
   logic             locked_q_r;
   logic [CNT_W-1:0] snap_r [0:3];
   logic [1:0]       idx_r;
   logic [CNT_W-1:0] max_r;
   logic [1:0]       win_r;
   logic             tie_r;
   logic [CNT_W+1:0] total_r;
   logic [31:0]      dwell_r;

   logic             rise_s;
   logic [CNT_W-1:0] cur_s;
   logic [CNT_W-1:0] max_nx_s;
   logic [1:0]       win_nx_s;
   logic             tie_nx_s;
   logic [CNT_W+1:0] total_nx_s;
   logic [1:0]       sel_nx_s;

   // Next accumulator values for the candidate currently being scanned
   always_comb begin
      rise_s     = locked & ~locked_q_r;
      cur_s      = snap_r[idx_r];
      total_nx_s = total_r + {2'b00, cur_s};
      sel_nx_s   = disp_sel + 2'd1;
      max_nx_s   = max_r;
      win_nx_s   = win_r;
      tie_nx_s   = tie_r;
      // strict compare keeps the lower index as winner on equal counts
      if (cur_s > max_r) begin
         max_nx_s = cur_s;
         win_nx_s = idx_r;
         tie_nx_s = 1'b0;
      end else if ((cur_s == max_r) && (max_r != {CNT_W{1'b0}})) begin
         tie_nx_s = 1'b1;
      end else begin
         tie_nx_s = tie_r;
      end
   end

   // Result state machine with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         locked_q_r   <= 1'b0;
         for (int i = 0; i < 4; i++) snap_r[i] <= {CNT_W{1'b0}};
         idx_r        <= 2'd0;
         max_r        <= {CNT_W{1'b0}};
         win_r        <= 2'd0;
         tie_r        <= 1'b0;
         total_r      <= {(CNT_W+2){1'b0}};
         dwell_r      <= 32'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         winner       <= 2'd0;
         winner_valid <= 1'b0;
         tie          <= 1'b0;
         max_count    <= {CNT_W{1'b0}};
         total        <= {(CNT_W+2){1'b0}};
         disp_sel     <= 2'd0;
         disp_count   <= {CNT_W{1'b0}};
      end else begin
         locked_q_r <= locked;
         case (state_r)
            ST_IDLE: begin
               if (rise_s) begin
                  snap_r[0] <= count1;
                  snap_r[1] <= count2;
                  snap_r[2] <= count3;
                  snap_r[3] <= count4;
                  idx_r     <= 2'd0;
                  max_r     <= {CNT_W{1'b0}};
                  win_r     <= 2'd0;
                  tie_r     <= 1'b0;
                  total_r   <= {(CNT_W+2){1'b0}};
                  busy      <= 1'b1;
                  state_r   <= ST_SCAN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SCAN, ST_DONE: begin
               if (!locked) begin
                  state_r      <= ST_IDLE;
                  idx_r        <= 2'd0;
                  dwell_r      <= 32'd0;
                  busy         <= 1'b0;
                  done         <= 1'b0;
                  winner       <= 2'd0;
                  winner_valid <= 1'b0;
                  tie          <= 1'b0;
                  max_count    <= {CNT_W{1'b0}};
                  total        <= {(CNT_W+2){1'b0}};
                  disp_sel     <= 2'd0;
                  disp_count   <= {CNT_W{1'b0}};
               end else if (state_r == ST_SCAN) begin
                  total_r <= total_nx_s;
                  max_r   <= max_nx_s;
                  win_r   <= win_nx_s;
                  tie_r   <= tie_nx_s;
                  idx_r   <= idx_r + 2'd1;
                  if (idx_r == 2'd3) begin
                     state_r      <= ST_DONE;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                     winner       <= win_nx_s;
                     winner_valid <= (max_nx_s != {CNT_W{1'b0}}) & ~tie_nx_s;
                     tie          <= tie_nx_s;
                     max_count    <= max_nx_s;
                     total        <= total_nx_s;
                     disp_sel     <= 2'd0;
                     disp_count   <= snap_r[0];
                     dwell_r      <= 32'd0;
                  end else begin
                     state_r <= ST_SCAN;
                  end
               end else begin
                  if (dwell_r >= DWELL_LAST) begin
                     dwell_r    <= 32'd0;
                     disp_sel   <= sel_nx_s;
                     disp_count <= snap_r[sel_nx_s];
                  end else begin
                     dwell_r <= dwell_r + 32'd1;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef TAMPER_CHECK_EN
   logic mismatch_s;

   // Any live tally differing from the snapshot while results are shown
   always_comb begin
      mismatch_s = (count1 != snap_r[0]) | (count2 != snap_r[1]) |
                   (count3 != snap_r[2]) | (count4 != snap_r[3]);
   end

   // Sticky tamper flag, cleared whenever the results are not being held
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tamper <= 1'b0;
      end else if ((state_r == ST_DONE) && locked) begin
         tamper <= tamper | mismatch_s;
      end else begin
         tamper <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_evm_result_unit.sv
// Self-checking bench for evm_result_unit: behavioural election model plus directed literal checks.
module tb_evm_result_unit;
   localparam int          CNT_W = 8;
   localparam int unsigned DWELL = 3;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             locked;
   logic [CNT_W-1:0] count1, count2, count3, count4;
   logic             busy, done, winner_valid, tie;
   logic [1:0]       winner, disp_sel;
   logic [CNT_W-1:0] max_count, disp_count;
   logic [CNT_W+1:0] total;
`ifdef TAMPER_CHECK_EN
   logic             tamper;
`endif

   always #5 clk = ~clk;

   evm_result_unit #(.CNT_W(CNT_W), .DWELL(DWELL)) dut (
      .clk(clk), .reset_n(reset_n), .locked(locked),
      .count1(count1), .count2(count2), .count3(count3), .count4(count4),
      .busy(busy), .done(done), .winner(winner), .winner_valid(winner_valid),
      .tie(tie), .max_count(max_count), .total(total),
      .disp_sel(disp_sel), .disp_count(disp_count)
`ifdef TAMPER_CHECK_EN
      , .tamper(tamper)
`endif
   );

   // Model: election active flag, edges since the snapshot edge, and the snapshot itself
   logic       m_act;
   int         m_age;
   logic       m_prev;
   logic [7:0] m_snap [4];
   logic       m_tamp;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_act  <= 1'b0;
         m_age  <= 0;
         m_prev <= 1'b0;
         m_tamp <= 1'b0;
      end else begin
         m_prev <= locked;
         if (m_act && m_age >= 4 && locked)
            m_tamp <= m_tamp | ({count1, count2, count3, count4} !=
                                {m_snap[0], m_snap[1], m_snap[2], m_snap[3]});
         else
            m_tamp <= 1'b0;
         if (!m_act) begin
            if (locked && !m_prev) begin
               m_act     <= 1'b1;
               m_age     <= 0;
               m_snap[0] <= count1;
               m_snap[1] <= count2;
               m_snap[2] <= count3;
               m_snap[3] <= count4;
            end
         end else if (!locked) begin
            m_act <= 1'b0;
         end else begin
            m_age <= m_age + 1;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output against what the election rules say it must be now
   task automatic compare_all();
      int  mx, tot, nmax, win, sel;
      bit  e_busy, e_done, e_tie;
      mx = 0; tot = 0; nmax = 0; win = 0; sel = 0;
      for (int i = 0; i < 4; i++) begin
         tot += int'(m_snap[i]);
         if (int'(m_snap[i]) > mx) mx = int'(m_snap[i]);
      end
      for (int i = 3; i >= 0; i--)
         if (int'(m_snap[i]) == mx) begin nmax++; win = i; end
      e_busy = m_act && (m_age < 4);
      e_done = m_act && (m_age >= 4);
      e_tie  = (mx != 0) && (nmax >= 2);
      if (e_done) sel = ((m_age - 4) / int'(DWELL)) % 4;
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("winner", winner, e_done ? win : 0);
      chk("winner_valid", winner_valid, e_done && (mx != 0) && !e_tie);
      chk("tie", tie, e_done && e_tie);
      chk("max_count", max_count, e_done ? mx : 0);
      chk("total", total, e_done ? tot : 0);
      chk("disp_sel", disp_sel, sel);
      chk("disp_count", disp_count, e_done ? int'(m_snap[sel]) : 0);
`ifdef TAMPER_CHECK_EN
      chk("tamper", tamper, m_tamp);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_counts(input int a, input int b, input int c, input int d);
      count1 = 8'(a); count2 = 8'(b); count3 = 8'(c); count4 = 8'(d);
   endtask

   // Directed election with hand-computed expected results
   task automatic elect(input int a, input int b, input int c, input int d,
                        input int ew, input int ewv, input int etie,
                        input int emax, input int etot, input int hold);
      int n;
      set_counts(a, b, c, d);
      locked = 1'b1;
      tick();
      n = 0;
      while (busy && n < 20) begin n++; tick(); end
      chk("lit_busy_cycles", n, 4);
      chk("lit_done", done, 1);
      chk("lit_winner", winner, ew);
      chk("lit_winner_valid", winner_valid, ewv);
      chk("lit_tie", tie, etie);
      chk("lit_max", max_count, emax);
      chk("lit_total", total, etot);
      for (int i = 0; i < hold; i++) begin
         if (i > 0) tick();
         chk("lit_disp_sel", disp_sel, (i / 3) % 4);
         case ((i / 3) % 4)
            0: chk("lit_disp_count", disp_count, a);
            1: chk("lit_disp_count", disp_count, b);
            2: chk("lit_disp_count", disp_count, c);
            default: chk("lit_disp_count", disp_count, d);
         endcase
         set_counts($urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255));
      end
      locked = 1'b0;
      tick();
      chk("lit_done_after_fall", done, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      locked  = 1'b0;
      set_counts(0, 0, 0, 0);
      repeat (3) tick();
      chk("lit_reset_busy", busy, 0);
      chk("lit_reset_total", total, 0);
      reset_n = 1'b1;
      tick();

      elect(5, 0, 9, 2, 2, 1, 0, 9, 16, 13);
      tick();
      elect(7, 7, 3, 0, 0, 0, 1, 7, 17, 4);
      tick();
      elect(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
      tick();
      elect(255, 255, 255, 255, 0, 0, 1, 255, 1020, 5);
      tick();
      elect(1, 2, 3, 4, 3, 1, 0, 4, 10, 1);
      tick();

      // Abort during scan: outputs clear and no done follows
      set_counts(9, 9, 9, 1);
      locked = 1'b1;
      tick();
      tick();
      locked = 1'b0;
      tick();
      chk("lit_abort_busy", busy, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("lit_abort_no_done", done, 0);
      end

      // Restart after abort with new counts
      elect(3, 8, 8, 1, 1, 0, 1, 8, 20, 3);

`ifdef TAMPER_CHECK_EN
      set_counts(4, 4, 4, 4);
      locked = 1'b1;
      repeat (5) tick();
      chk("lit_tamper_clean", tamper, 0);
      count1 = 8'd5;
      tick();
      count1 = 8'd4;
      tick();
      chk("lit_tamper_sticky", tamper, 1);
      locked = 1'b0;
      tick();
      chk("lit_tamper_clear", tamper, 0);
`endif

      // Reset in the middle of a scan
      set_counts(1, 2, 3, 4);
      locked = 1'b1;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      chk("lit_async_reset_busy", busy, 0);
      tick();
      locked  = 1'b0;
      reset_n = 1'b1;
      tick();

      // Randomised elections, including near-tie counts, churn and aborts
      for (int e = 0; e < 40; e++) begin
         int hold;
         if (e % 2 == 0)
            set_counts($urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
         else
            set_counts($urandom_range(0, 255), $urandom_range(0, 255),
                       $urandom_range(0, 255), $urandom_range(0, 255));
         locked = 1'b1;
         hold = $urandom_range(1, 25);
         for (int i = 0; i < hold; i++) begin
            tick();
            if ($urandom_range(0, 3) == 0)
               set_counts($urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 255));
         end
         locked = 1'b0;
         repeat ($urandom_range(1, 3)) tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
